// File: rtl/int_sequencer.sv
// int_sequencer: interrupt sequencer between the flag sources and the CPU.
// Applies IE masking and two-level IP priority, tracks in-service levels
// for nesting, raises a vectored-call request at instruction boundaries,
// strobes hardware flag clears when a vector is taken, and retires the
// in-service level on RETI.
//
// Handshake: int_req rises one cycle after an accepted instr_boundary and
// stays high, with int_vector/int_src frozen, until int_ack is seen. The
// cycle after int_ack, int_req drops and flag_clr pulses for one cycle.
// int_ack while int_req is low is ignored.
//
// The FSM state is directly visible as int_req (high exactly in REQ).
//
// Optional build macro INT_SEQ_STATUS_EN adds the pend_vec and nest_err
// debug outputs.
module int_sequencer #(
    parameter logic [15:0] VEC_BASE   = 16'h0003,
    parameter int unsigned VEC_STRIDE = 8,
    parameter int unsigned NSRC       = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      ie,
    input  logic [NSRC-1:0] ip,
    input  logic [NSRC-1:0] src_pend,
    input  logic [NSRC-1:0] src_autoclr,
    input  logic            instr_boundary,
    input  logic            reti,
    input  logic            sfr_ie_ip_wr,
    input  logic            int_ack,
    output logic            int_req,
    output logic [15:0]     int_vector,
    output logic [NSRC-1:0] int_src,
    output logic [NSRC-1:0] flag_clr,
    output logic            isr_hi,
    output logic            isr_lo
`ifdef INT_SEQ_STATUS_EN
    ,
    output logic [NSRC-1:0] pend_vec,
    output logic            nest_err
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            hold;
    logic            lvl_hi;

    logic [NSRC-1:0] cand;
    logic [NSRC-1:0] hi_cand;
    logic [NSRC-1:0] sel;
    logic            win_hi;
    logic            win_valid;
    logic [2:0]      win_idx;
    logic [15:0]     win_vec;
    logic            eligible;
    logic            blocked;
    logic            take;
    logic            ack_take;
    logic            clr_hi;
    logic            clr_lo;

    // IE bits 6:5 are reserved and do not take part in arbitration.
    logic            unused_ie;
    assign unused_ie = ^ie[6:5];

    // Candidate masking, priority pick and eligibility against in-service levels.
    always_comb begin
        cand      = {NSRC{ie[7]}} & ie[NSRC-1:0] & src_pend;
        hi_cand   = cand & ip;
        win_hi    = |hi_cand;
        win_valid = |cand;
        sel       = win_hi ? hi_cand : cand;
        win_idx   = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (sel[i]) begin
                win_idx = 3'(i);
            end
        end
        win_vec  = VEC_BASE + 16'(VEC_STRIDE) * 16'(win_idx);
        eligible = win_valid && !isr_hi && (win_hi || !isr_lo);
        blocked  = hold || reti || sfr_ie_ip_wr;
        take     = (state == IDLE) && instr_boundary && !blocked && eligible;
        ack_take = (state == REQ) && int_ack;
        // RETI retires the highest active level only.
        clr_hi   = reti && isr_hi;
        clr_lo   = reti && !isr_hi && isr_lo;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: a boundary launches a request, the ack ends it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (take)    state_next = REQ;
            REQ:     if (int_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign int_req = (state == REQ);

    // Request payload, level latch, hold, flag-clear strobe and in-service bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold       <= 1'b0;
            lvl_hi     <= 1'b0;
            int_src    <= '0;
            int_vector <= '0;
            flag_clr   <= '0;
            isr_hi     <= 1'b0;
            isr_lo     <= 1'b0;
        end else begin
            // Any boundary consumes the hold, so exactly one instruction runs
            // after RETI or an IE/IP write before a new vector is taken.
            hold     <= instr_boundary ? 1'b0 : (hold || reti || sfr_ie_ip_wr);
            flag_clr <= ack_take ? (int_src & src_autoclr) : '0;
            if (take) begin
                int_src    <= NSRC'(1) << win_idx;
                int_vector <= win_vec;
                lvl_hi     <= win_hi;
            end else if (ack_take) begin
                int_src    <= '0;
                int_vector <= '0;
            end
            // Retire first, then record the newly accepted level.
            isr_hi <= (isr_hi && !clr_hi) || (ack_take && lvl_hi);
            isr_lo <= (isr_lo && !clr_lo) || (ack_take && !lvl_hi);
        end
    end

`ifdef INT_SEQ_STATUS_EN
    // Debug readback: currently eligible candidates and sticky RETI underflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_vec <= '0;
            nest_err <= 1'b0;
        end else begin
            pend_vec <= cand & (isr_hi ? '0 : (isr_lo ? ip : '1));
            nest_err <= nest_err || (reti && !isr_hi && !isr_lo);
        end
    end
`endif

endmodule

// File: tb/tb_int_sequencer.sv
// Bench for int_sequencer: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural
// model of the interrupt rules.
module tb_int_sequencer;

    localparam int VB = 3;
    localparam int VS = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ie = '0;
    logic [4:0]  ip = '0;
    logic [4:0]  src_pend = '0;
    logic [4:0]  src_autoclr = '0;
    logic        instr_boundary = 1'b0;
    logic        reti = 1'b0;
    logic        sfr_ie_ip_wr = 1'b0;
    logic        int_ack = 1'b0;
    logic        int_req;
    logic [15:0] int_vector;
    logic [4:0]  int_src;
    logic [4:0]  flag_clr;
    logic        isr_hi;
    logic        isr_lo;
`ifdef INT_SEQ_STATUS_EN
    logic [4:0]  pend_vec;
    logic        nest_err;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    int_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .ie             (ie),
        .ip             (ip),
        .src_pend       (src_pend),
        .src_autoclr    (src_autoclr),
        .instr_boundary (instr_boundary),
        .reti           (reti),
        .sfr_ie_ip_wr   (sfr_ie_ip_wr),
        .int_ack        (int_ack),
        .int_req        (int_req),
        .int_vector     (int_vector),
        .int_src        (int_src),
        .flag_clr       (flag_clr),
        .isr_hi         (isr_hi),
        .isr_lo         (isr_lo)
`ifdef INT_SEQ_STATUS_EN
        ,
        .pend_vec       (pend_vec),
        .nest_err       (nest_err)
`endif
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pending request (by source index), level in service
    // as a two-entry array, the post-RETI/IE-write hold, and the clear strobe.
    bit         m_req;
    int         m_idx;
    bit         m_lvl;
    bit         m_hold;
    bit         m_svc[2];
    logic [4:0] m_flag;

    function automatic int pick_winner(input logic [7:0] e, input logic [4:0] p,
                                       input logic [4:0] pend, output bit hi);
        int best = -1;
        hi = 1'b0;
        if (e[7]) begin
            for (int n = 0; n < 5; n++)
                if (best < 0 && e[n] && pend[n] && p[n]) begin
                    best = n;
                    hi   = 1'b1;
                end
            for (int n = 0; n < 5; n++)
                if (best < 0 && e[n] && pend[n]) best = n;
        end
        return best;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int         w;
        bit         hi;
        bit         ok;
        bit         acked;
        logic [4:0] nf;
        if (rst) begin
            m_req = 0; m_idx = 0; m_lvl = 0; m_hold = 0;
            m_svc[0] = 0; m_svc[1] = 0; m_flag = '0;
        end else begin
            w     = pick_winner(ie, ip, src_pend, hi);
            ok    = (w >= 0) && !m_svc[1] && (hi || !m_svc[0]);
            acked = m_req && int_ack;
            nf    = acked ? (5'(1 << m_idx) & src_autoclr) : 5'd0;
            if (reti) begin
                if (m_svc[1]) m_svc[1] = 0;
                else          m_svc[0] = 0;
            end
            if (acked) m_svc[m_lvl] = 1;
            if (m_req) begin
                if (int_ack) m_req = 0;
            end else if (instr_boundary && !(m_hold || reti || sfr_ie_ip_wr) && ok) begin
                m_req = 1; m_idx = w; m_lvl = hi;
            end
            m_hold = instr_boundary ? 1'b0 : (m_hold || reti || sfr_ie_ip_wr);
            m_flag = nf;
        end
    end

    // Scoreboard compare, once per cycle away from the active edge.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("int_req",    32'(int_req),    32'(m_req));
            check("int_vector", 32'(int_vector), m_req ? 32'(VB + VS * m_idx) : 32'd0);
            check("int_src",    32'(int_src),    m_req ? 32'(1 << m_idx) : 32'd0);
            check("flag_clr",   32'(flag_clr),   32'(m_flag));
            check("isr_hi",     32'(isr_hi),     32'(m_svc[1]));
            check("isr_lo",     32'(isr_lo),     32'(m_svc[0]));
        end
    end

    // Driver tasks
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        ie = '0; ip = '0; src_pend = '0; src_autoclr = '0;
        instr_boundary = 0; reti = 0; sfr_ie_ip_wr = 0; int_ack = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic pulse_boundary();
        instr_boundary = 1; tick(); instr_boundary = 0;
    endtask

    task automatic pulse_ack();
        int_ack = 1; tick(); int_ack = 0;
    endtask

    initial begin
        tick();
        do_reset();
        chk_en = 1;
        check("reset int_req", 32'(int_req), 0);
        check("reset isr", 32'({isr_hi, isr_lo}), 0);
        check("reset int_vector", 32'(int_vector), 0);

        // TF0 alone, low priority, auto-cleared.
        ie = 8'h82; src_pend = 5'b00010; src_autoclr = 5'b00010;
        pulse_boundary();
        check("s1 req", 32'(int_req), 1);
        check("s1 vec", 32'(int_vector), 32'h000B);
        check("s1 src", 32'(int_src), 32'b00010);
        pulse_ack();
        check("s1 flag_clr", 32'(flag_clr), 32'b00010);
        check("s1 isr_lo", 32'(isr_lo), 1);
        tick();
        check("s1 flag_clr one cycle", 32'(flag_clr), 0);

        // High-level serial beats low-level IE0.
        do_reset();
        ie = 8'h9F; ip = 5'b10000; src_pend = 5'b10001; src_autoclr = 5'b00001;
        pulse_boundary();
        check("s2 vec", 32'(int_vector), 32'h0023);
        pulse_ack();
        check("s2 isr_hi", 32'(isr_hi), 1);
        check("s2 flag_clr", 32'(flag_clr), 0);

        // Nesting: high IE1 preempts in-service low TF0.
        do_reset();
        ie = 8'h8F; ip = 5'b00100; src_pend = 5'b00010; src_autoclr = 5'b01010;
        pulse_boundary(); pulse_ack();
        src_pend = 5'b00100;
        pulse_boundary();
        check("s3 nested req", 32'(int_req), 1);
        check("s3 nested vec", 32'(int_vector), 32'h0013);
        pulse_ack();
        // Same with IE1 low priority: no nesting.
        do_reset();
        ie = 8'h8F; ip = 5'b00000; src_pend = 5'b00010;
        pulse_boundary(); pulse_ack();
        src_pend = 5'b00100;
        pulse_boundary();
        check("s3 low no req", 32'(int_req), 0);

        // RETI retires high level and blocks the next boundary.
        do_reset();
        ie = 8'h8F; ip = 5'b01100; src_pend = 5'b00010;
        pulse_boundary(); pulse_ack();
        src_pend = 5'b00100;
        pulse_boundary(); pulse_ack();
        src_pend = 5'b01000;
        reti = 1; tick(); reti = 0;
        check("s4 isr_hi retired", 32'(isr_hi), 0);
        check("s4 isr_lo kept", 32'(isr_lo), 1);
        pulse_boundary();
        check("s4 blocked", 32'(int_req), 0);
        pulse_boundary();
        check("s4 vec", 32'(int_vector), 32'h001B);
        pulse_ack();

        // Request stays latched across pend drop, IE write and boundaries.
        do_reset();
        ie = 8'h82; src_pend = 5'b00010;
        pulse_boundary();
        src_pend = 5'b00000; ie = 8'h00;
        sfr_ie_ip_wr = 1; tick(); sfr_ie_ip_wr = 0;
        pulse_boundary();
        check("s5 req held", 32'(int_req), 1);
        check("s5 vec held", 32'(int_vector), 32'h000B);
        pulse_ack();
        check("s5 released", 32'(int_req), 0);

        // Asynchronous reset while a nested request is pending.
        do_reset();
        ie = 8'h8F; ip = 5'b00100; src_pend = 5'b00010; src_autoclr = 5'b11111;
        pulse_boundary(); pulse_ack();
        src_pend = 5'b00100;
        pulse_boundary();
        int_ack = 1;
        #2 rst = 1;
        #1;
        check("s6 async req", 32'(int_req), 0);
        check("s6 async isr", 32'({isr_hi, isr_lo}), 0);
        tick();
        rst = 0; int_ack = 0;
        tick();
        check("s6 no flag_clr", 32'(flag_clr), 0);

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            ie             = {($urandom_range(0, 5) != 0), 2'b00, 5'($urandom)};
            if ($urandom_range(0, 7) == 0) ip = 5'($urandom);
            src_pend       = 5'($urandom);
            src_autoclr    = 5'($urandom);
            instr_boundary = ($urandom_range(0, 2) == 0);
            reti           = ($urandom_range(0, 9) == 0);
            sfr_ie_ip_wr   = ($urandom_range(0, 11) == 0);
            int_ack        = ($urandom_range(0, 2) == 0);
            if (c == 2000) begin
                #2 rst = 1;
                #2 rst = 0;
            end
            tick();
        end
        clear_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/int_sequencer.md
Name: int_sequencer

Overview:
Interrupt controller that sits between the timer/serial/external-interrupt flag sources and the CPU control unit.
- Applies IE enable masking and two-level IP priority.
- Tracks in-service levels for nesting and issues the vectored-call request to the CPU at instruction boundaries.
- Pulses hardware flag-clear strobes back to TCON when a vector is taken, and retires in-service state on RETI.

Parameters:
VEC_BASE, 16'h0003, vector address of source 0
VEC_STRIDE, 8, address step between consecutive source vectors
NSRC, 5, number of sources (fixed at 5; only the default is supported)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
ie  in  8  IE SFR; bit7 = EA, bits4:0 = per-source enable
ip  in  5  IP SFR; 1 = high priority for that source
src_pend  in  5  pending flags, index 0..4 = IE0, TF0, IE1, TF1, RI|TI
src_autoclr  in  5  1 = flag is hardware-cleared on vectoring (TF0/TF1 always; IE0/IE1 in edge mode; serial never)
instr_boundary  in  1  one-cycle pulse on the last cycle of each instruction
reti  in  1  one-cycle pulse when a RETI executes
sfr_ie_ip_wr  in  1  one-cycle pulse when an instruction writes IE or IP
int_ack  in  1  CPU has accepted the vector (LCALL started)
int_req  out  1  vectored call request
int_vector  out  16  target address; valid while int_req is high
int_src  out  5  one-hot source being vectored
flag_clr  out  5  one-cycle clear strobes to the flag owners
isr_hi  out  1  high-level interrupt in service
isr_lo  out  1  low-level interrupt in service

Behaviour:
- Reset (asynchronous, any time, including mid-request): state=IDLE; int_req=0; int_vector=0; int_src=0; flag_clr=0; isr_hi=0; isr_lo=0; hold=0.
- cand[n] = ie[7] & ie[n] & src_pend[n].
- Winner selection:
  - If any cand has ip=1, the winner is the lowest index among those.
  - Otherwise the winner is the lowest index among all cand.
- Eligibility:
  - High-level winner: requires isr_hi=0.
  - Low-level winner: requires isr_hi=0 and isr_lo=0.
- Block:
  - A reti or sfr_ie_ip_wr pulse sets hold.
  - An instr_boundary with hold=1 or a coincident reti/sfr_ie_ip_wr issues no request and leaves hold=0 afterwards.
  - Net effect: one further instruction always executes after RETI or an IE/IP write.
- State machine:
  - IDLE -> REQ: on instr_boundary, not blocked, eligible winner present. Next cycle: int_req=1, int_src=onehot(winner), int_vector=VEC_BASE+VEC_STRIDE*winner (8-bit index multiplied, zero-extended, 16-bit add, wrap ignored).
  - While in REQ, int_req/int_src/int_vector stay latched even if src_pend drops, ie/ip change, or further boundaries arrive. New boundaries are ignored.
  - REQ -> IDLE: on int_ack.
    - Next cycle: int_req=0, int_vector=0, int_src=0.
    - flag_clr = int_src & src_autoclr, sampled at the ack cycle and high for exactly one cycle.
    - In-service bit for the winner's latched level is set.
  - int_ack in IDLE is ignored.
- RETI retire: clears isr_hi if set, else clears isr_lo. No effect if neither is set.
- In-service update order in a cycle: isr = (isr & ~reti_clear) | ack_set. A simultaneous reti and ack therefore retires the old level and records the new one.
- Latency: boundary to int_req = 1 cycle; ack to flag_clr/isr update = 1 cycle.
- A level latched at REQ entry is used at ack; IP changes during REQ do not alter it.

Optional Feature:
INT_SEQ_STATUS_EN
- Defined: adds output pend_vec[4:0], registered each cycle = cand masked by current eligibility, for debug/SFR readback.
- Also adds output nest_err, set sticky when reti arrives with isr_hi=isr_lo=0; cleared only by rst.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Setup: ie=8'h82, src_pend=5'b00010, src_autoclr=5'b00010; pulse instr_boundary. Expect: int_req=1 next cycle, int_vector=16'h000B, int_src=5'b00010. Ack -> flag_clr=5'b00010 for 1 cycle, isr_lo=1.
- Setup: ie=8'h9F, ip=5'b10000, src_pend=5'b10001; boundary. Expect: int_vector=16'h0023 (high-level serial beats low-level IE0); on ack isr_hi=1, flag_clr=0 (serial not autoclr).
- Setup: isr_lo=1 (TF0 serviced); IE1 pending with ip[2]=1; boundary. Expect: nested request, int_vector=16'h0013. Same test with ip[2]=0 -> no int_req.
- Setup: pulse reti with isr_hi=1, isr_lo=1, TF1 pending; boundary. Expect: isr_hi=0 and no request at that boundary; request 16'h001B at the following boundary.
- Setup: enter REQ, drop src_pend to 0 and pulse sfr_ie_ip_wr. Expect: int_req stays 1 with the same vector until ack.
- Setup: assert rst while in REQ. Expect: int_req=0, isr_hi/isr_lo=0 immediately, with no flag_clr pulse.
